// File: rtl/fhe_xbar_axi_master.sv
// ---------------------------------------------------------------------------
// fhe_xbar_axi_master
//
// AXI4 full master that loads one Benes-interconnect frame into the FHE
// crossbar AXI slave and reads the routed result back.
//
// A frame is SLOT_NUM data beats followed by one switch-select config beat,
// written as a single INCR burst of SLOT_NUM+1 beats. After the write
// response the block issues one INCR read burst of SLOT_NUM beats and
// forwards the returned beats to a downstream valid/ready stream.
//
// Ports
//   M_AXI_ACLK      clock
//   M_AXI_ARESETN   synchronous active-low reset
//   start           single-cycle frame request, honoured only when idle
//   busy            high whenever a frame is in progress
//   done            one-cycle pulse at frame completion
//   err[1:0]        sticky: [0] response error, [1] RLAST misplaced;
//                   cleared when a start is accepted
//   in_*            frame beat stream (last beat is the config beat)
//   out_*           readback beat stream
//   M_AXI_AW*/W*/B*/AR*/R*  AXI4 master channels
// ---------------------------------------------------------------------------
module fhe_xbar_axi_master #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_M_AXI_ADDR_WIDTH = 10,
    // Matches SLOT_NUM_IN_BUFF of the FHE ALU package; minimum 1.
    parameter int SLOT_NUM           = 8,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,

    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        err,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     in_data,
    input  logic                              in_valid,
    output logic                              in_ready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     out_data,
    output logic                              out_valid,
    input  logic                              out_ready,

    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    // Counter wide enough to hold SLOT_NUM (index of the config beat).
    localparam int CNT_W = $clog2(SLOT_NUM + 2);

    localparam logic [7:0] AW_LEN     = 8'(SLOT_NUM);      // SLOT_NUM+1 beats
    localparam logic [7:0] AR_LEN     = 8'(SLOT_NUM - 1);  // SLOT_NUM beats
    localparam logic [2:0] AXI_SIZE   = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] rcnt;

    logic w_fire;
    logic w_last;
    logic r_fire;
    logic r_final;

    assign w_last  = (wcnt == CNT_W'(SLOT_NUM));
    assign r_final = (rcnt == CNT_W'(SLOT_NUM - 1));
    assign w_fire  = M_AXI_WVALID & M_AXI_WREADY;
    assign r_fire  = M_AXI_RVALID & M_AXI_RREADY;

    // ------------------------------------------------------------------
    // Sequencer. Errors are only recorded; the frame always runs to DONE
    // so the slave never sees a truncated burst.
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            rcnt  <= '0;
            err   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_AW;
                        err   <= '0;
                        wcnt  <= '0;
                        rcnt  <= '0;
                    end
                end
                ST_AW: begin
                    if (M_AXI_AWREADY) state <= ST_W;
                end
                ST_W: begin
                    if (w_fire) begin
                        wcnt <= wcnt + 1'b1;
                        if (w_last) state <= ST_B;
                    end
                end
                ST_B: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) err[0] <= 1'b1;
                        state <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (M_AXI_ARREADY) state <= ST_R;
                end
                ST_R: begin
                    if (r_fire) begin
                        rcnt <= rcnt + 1'b1;
                        if (M_AXI_RRESP != 2'b00) err[0] <= 1'b1;
                        // RLAST must coincide exactly with our own last beat.
                        if (M_AXI_RLAST != r_final) err[1] <= 1'b1;
                        // Our beat count, not RLAST, ends the burst.
                        if (r_final) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Write address channel
    // ------------------------------------------------------------------
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = BASE_ADDR;
    assign M_AXI_AWLEN   = AW_LEN;
    assign M_AXI_AWSIZE  = AXI_SIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = (state == ST_AW);

    // ------------------------------------------------------------------
    // Write data channel: the input stream is wired straight through so a
    // beat can move every cycle; only the handshake is gated by state.
    // ------------------------------------------------------------------
    assign M_AXI_WDATA  = in_data;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_WLAST  = (state == ST_W) & w_last;
    assign M_AXI_WVALID = (state == ST_W) & in_valid;
    assign in_ready     = (state == ST_W) & M_AXI_WREADY;

    // ------------------------------------------------------------------
    // Write response channel
    // ------------------------------------------------------------------
    assign M_AXI_BREADY = (state == ST_B);

    // ------------------------------------------------------------------
    // Read address channel
    // ------------------------------------------------------------------
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = BASE_ADDR;
    assign M_AXI_ARLEN   = AR_LEN;
    assign M_AXI_ARSIZE  = AXI_SIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARVALID = (state == ST_AR);

    // ------------------------------------------------------------------
    // Read data channel: pass-through to the output stream.
    // ------------------------------------------------------------------
    assign out_data     = M_AXI_RDATA;
    assign out_valid    = (state == ST_R) & M_AXI_RVALID;
    assign M_AXI_RREADY = (state == ST_R) & out_ready;

endmodule

// File: tb/tb_fhe_xbar_axi_master.sv
// ---------------------------------------------------------------------------
// tb_fhe_xbar_axi_master
//
// Drives frames into fhe_xbar_axi_master while playing both the crossbar
// slave and the two streams. The slave routes readback beat i to
// frame[(i + cfg) % SLOT_NUM] ^ {cfg word}; the expected readback is derived
// from the frame the bench generated, not from what the slave captured.
// ---------------------------------------------------------------------------
module tb_fhe_xbar_axi_master;

    localparam int DW  = 512;
    localparam int AW  = 10;
    localparam int IDW = 1;
    localparam int SN  = 8;
    localparam logic [AW-1:0] BASE = 10'h040;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start;
    logic              busy, done;
    logic [1:0]        err;
    logic [DW-1:0]     in_data;
    logic              in_valid, in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid, out_ready;
    logic [IDW-1:0]    awid, arid;
    logic [AW-1:0]     awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize, awprot, arprot;
    logic [1:0]        awburst, arburst;
    logic              awlock, arlock;
    logic [3:0]        awcache, arcache, awqos, arqos;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast, wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic              arvalid, arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;

    fhe_xbar_axi_master #(
        .C_M_AXI_ID_WIDTH   (IDW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .SLOT_NUM           (SN),
        .BASE_ADDR          (BASE)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .M_AXI_AWID    (awid),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWLOCK  (awlock),
        .M_AXI_AWCACHE (awcache),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWQOS   (awqos),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARID    (arid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARLOCK  (arlock),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARQOS   (arqos),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    int n_pass   = 0;
    int n_checks = 0;

    logic [DW-1:0] frame [SN+1];  // what the bench sends
    logic [DW-1:0] wmem  [SN+1];  // what the slave captured

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Routing rule of the crossbar slave, applied to a given frame image.
    function automatic logic [DW-1:0] routed(input logic [DW-1:0] img [SN+1], input int i);
        logic [DW-1:0] cfg;
        cfg = img[SN];
        return img[(i + int'(cfg[7:0])) % SN] ^ {(DW/32){cfg[31:0]}};
    endfunction

    function automatic bit rnd_ready(input bit stall);
        return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic idle_inputs();
        start = 0; in_valid = 0; in_data = '0; out_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
    endtask

    // One complete frame. Negative int arguments disable that feature.
    task automatic run_frame(input string nm, input bit nominal, input bit stall,
                             input logic [1:0] b_resp, input int rresp_bad, input int rlast_bad,
                             input int in_gap_at, input int in_gap_len,
                             input int out_gap_at, input int out_gap_len,
                             input bit extra_start, input int rst_at_w);
        int cyc, w_idx, r_idx, aw_n, ar_n, done_n, viol, busy_drop, gap_in, gap_out, b_wait;
        bit aw_done, w_done, b_pend, b_done, ar_done, finished, xs_w, xs_r, rst_fired;
        logic [1:0] err_exp;

        for (int i = 0; i <= SN; i++)
            frame[i] = nominal ? ((i == SN) ? DW'(24'hC0FFEE) : DW'(i + 1)) : rand_beat();
        err_exp = {rlast_bad >= 0, (b_resp != 2'b00) || (rresp_bad >= 0)};

        cyc = 0; w_idx = 0; r_idx = 0; aw_n = 0; ar_n = 0; done_n = 0; viol = 0;
        busy_drop = 0; gap_in = 0; gap_out = 0; b_wait = 0;
        aw_done = 0; w_done = 0; b_pend = 0; b_done = 0; ar_done = 0;
        finished = 0; xs_w = 0; xs_r = 0; rst_fired = 0;

        while (!finished && cyc < 400) begin
            @(negedge clk);
            if (rst_fired) begin
                // Cycle after the reset edge: peers still offer traffic.
                rst_n = 1; start = 0; in_valid = 1; wready = 1; out_ready = 1;
                awready = 1; arready = 1; bvalid = 1; rvalid = 1;
                #1;
                check({nm, "/after_reset"},
                      DW'({busy, done, awvalid, wvalid, in_ready, bready, arvalid, rready, out_valid}), '0);
                check({nm, "/err_after_reset"}, DW'(err), '0);
                finished = 1;
            end else begin
                // ---- drive peers ----
                start = (cyc == 0);
                if (extra_start && !xs_w && aw_done && !w_done && w_idx == 2) begin start = 1; xs_w = 1; end
                if (extra_start && !xs_r && ar_done && r_idx == 3) begin start = 1; xs_r = 1; end
                awready = rnd_ready(stall);
                wready  = rnd_ready(stall);
                arready = rnd_ready(stall);
                if (gap_in > 0) begin
                    in_valid = 0; gap_in--;
                end else begin
                    in_valid = (w_idx <= SN) ? rnd_ready(stall) : 1'b0;
                end
                in_data = (w_idx <= SN) ? frame[w_idx] : '0;
                if (rst_at_w >= 0 && w_idx == rst_at_w) begin
                    rst_n = 0; in_valid = 0; rst_fired = 1;
                end
                bresp = b_resp;
                if (b_pend && b_wait > 0) begin bvalid = 0; b_wait--; end
                else bvalid = b_pend;
                rvalid = ar_done && r_idx < SN && rnd_ready(stall);
                rdata  = (r_idx < SN) ? routed(wmem, r_idx) : '0;
                rlast  = (rlast_bad >= 0) ? (r_idx == rlast_bad) : (r_idx == SN - 1);
                rresp  = (r_idx == rresp_bad) ? 2'b10 : 2'b00;
                if (gap_out > 0) begin out_ready = 0; gap_out--; end
                else out_ready = rnd_ready(stall);
                #1;

                // ---- observe ----
                if (cyc == 0) check({nm, "/busy_idle"}, DW'(busy), '0);
                if (cyc == 1) begin
                    check({nm, "/awvalid_t+1"}, DW'(awvalid), DW'(1'b1));
                    check({nm, "/err_cleared"}, DW'(err), '0);
                end
                if (cyc >= 1 && done_n == 0 && busy !== 1'b1) busy_drop++;

                if (aw_done && awvalid) viol++;
                if ((!aw_done || w_done) && (in_ready || wvalid)) viol++;
                if (aw_done && !w_done && (wvalid !== in_valid || in_ready !== wready)) viol++;
                if ((!w_done || b_done) && bready) viol++;
                if ((!b_done || ar_done) && arvalid) viol++;
                if ((!ar_done || r_idx == SN) && (rready || out_valid)) viol++;
                if (ar_done && r_idx < SN && (rready !== out_ready || out_valid !== rvalid)) viol++;

                if (awvalid && awready) begin
                    aw_n++;
                    if (aw_n == 1) begin
                        check({nm, "/aw_fields"}, DW'({awaddr, awlen, awsize, awburst}),
                              DW'({BASE, 8'(SN), 3'd6, 2'b01}));
                        check({nm, "/aw_tied"}, DW'({awid, awlock, awcache, awprot, awqos}), '0);
                    end
                    aw_done = 1;
                end
                if (wvalid && wready) begin
                    if (w_idx > SN) viol++;
                    else begin
                        check($sformatf("%s/wdata%0d", nm, w_idx), wdata, frame[w_idx]);
                        check($sformatf("%s/wlast%0d", nm, w_idx), DW'(wlast), DW'(w_idx == SN));
                        if (w_idx == 0) check({nm, "/wstrb"}, DW'(wstrb), DW'({(DW/8){1'b1}}));
                        wmem[w_idx] = wdata;
                    end
                    w_idx++;
                    if (w_idx == in_gap_at) gap_in = in_gap_len;
                    if (w_idx == SN + 1) begin
                        w_done = 1; b_pend = 1;
                        b_wait = stall ? $urandom_range(0, 2) : 0;
                    end
                end
                if (bvalid && bready) begin b_pend = 0; b_done = 1; end
                if (arvalid && arready) begin
                    ar_n++;
                    if (ar_n == 1)
                        check({nm, "/ar_fields"}, DW'({araddr, arlen, arsize, arburst, arid}),
                              DW'({BASE, 8'(SN - 1), 3'd6, 2'b01, {IDW{1'b0}}}));
                    ar_done = 1;
                end
                if (rvalid && rready) begin
                    check($sformatf("%s/rdata%0d", nm, r_idx), out_data, routed(frame, r_idx));
                    r_idx++;
                    if (r_idx == out_gap_at) gap_out = out_gap_len;
                end
                if (done === 1'b1) begin
                    done_n++;
                    check({nm, "/err_at_done"}, DW'(err), DW'(err_exp));
                    check({nm, "/reads_at_done"}, DW'(r_idx), DW'(SN));
                    finished = 1;
                end
                cyc++;
            end
        end

        check({nm, "/completed"}, DW'(finished), DW'(1'b1));
        if (!rst_fired) begin
            check({nm, "/aw_count"}, DW'(aw_n), DW'(1));
            check({nm, "/ar_count"}, DW'(ar_n), DW'(1));
            check({nm, "/w_beats"}, DW'(w_idx), DW'(SN + 1));
            check({nm, "/protocol"}, DW'(viol), '0);
            check({nm, "/busy_held"}, DW'(busy_drop), '0);
            @(negedge clk);
            idle_inputs();
            #1;
            check({nm, "/idle_after_done"}, DW'({busy, done}), '0);
            check({nm, "/err_sticky"}, DW'(err), DW'(err_exp));
        end else begin
            check({nm, "/no_done_on_reset"}, DW'(done_n), '0);
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset/outputs",
              DW'({busy, done, awvalid, wvalid, in_ready, bready, arvalid, rready, out_valid}), '0);
        check("reset/err", DW'(err), '0);
        @(negedge clk);
        rst_n = 1;

        //        name       nom stall bresp  rrb rlb  ig  igl og  ogl xs  rst
        run_frame("nominal", 1,  0,    2'b00, -1, -1,  -1, 0,  -1, 0,  0, -1);
        run_frame("gaps",    1,  0,    2'b00, -1, -1,   4, 3,   2, 2,  0, -1);
        run_frame("bresp",   0,  1,    2'b10, -1, -1,  -1, 0,  -1, 0,  0, -1);
        run_frame("clean",   0,  0,    2'b00, -1, -1,  -1, 0,  -1, 0,  0, -1);
        run_frame("rlast",   0,  1,    2'b00, -1,  5,  -1, 0,  -1, 0,  0, -1);
        run_frame("xstart",  0,  1,    2'b00, -1, -1,  -1, 0,  -1, 0,  1, -1);
        run_frame("reset",   0,  0,    2'b00, -1, -1,  -1, 0,  -1, 0,  0,  3);
        run_frame("post_rst",0,  0,    2'b00, -1, -1,  -1, 0,  -1, 0,  0, -1);
        run_frame("rresp",   0,  1,    2'b00,  3, -1,  -1, 0,  -1, 0,  0, -1);
        for (int k = 0; k < 4; k++)
            run_frame($sformatf("rand%0d", k), 0, 1, 2'($urandom_range(0, 3)), -1, -1,
                      $urandom_range(1, SN), $urandom_range(0, 3),
                      $urandom_range(1, SN - 1), $urandom_range(0, 3), 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
